// File: rtl/tm1637_frame_xfer.sv
// ---------------------------------------------------------------------------
// tm1637_frame_xfer
//
// Sends one complete TM1637 frame on open-drain SCL/SDA pads. A frame is a
// start condition, then one or more bytes sent LSB first, each followed by
// an ACK slot, and finally a stop condition. Bytes arrive on a valid/ready
// stream. The frame ends after the byte flagged in_last, or after a NACK
// when ABORT_ON_NACK is set. Every bus phase lasts HALF_PERIOD clocks.
//
// Ports:
//   clk, rst              system clock, asynchronous active-low reset
//   in_valid/in_ready     byte stream handshake (accept when both high)
//   in_data, in_last      byte to send (LSB first) and end-of-frame marker
//   busy                  frame in progress
//   done                  one-cycle pulse when the stop condition completes
//   ack_err               at least one NACK in the current/last frame
//   bytes_sent            bytes whose ACK slot completed (saturating)
//   scl_en/scl_out        SCL pad: enable = pull low, data is constant 0
//   sda_en/sda_out        SDA pad: enable = pull low, data is constant 0
//   sda_in                raw SDA pad input (asynchronous)
// ---------------------------------------------------------------------------
module tm1637_frame_xfer #(
    parameter int HALF_PERIOD   = 256,
    parameter bit ABORT_ON_NACK = 1'b1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             busy,
    output logic             done,
    output logic             ack_err,
    output logic [CNT_W-1:0] bytes_sent,
    output logic             scl_en,
    output logic             scl_out,
    output logic             sda_en,
    output logic             sda_out,
    input  logic             sda_in
);

    localparam int            PW     = $clog2(HALF_PERIOD);
    localparam logic [PW-1:0] RELOAD = PW'(HALF_PERIOD - 1);

    typedef enum logic [3:0] {
        IDLE,
        START,
        BIT_LO,
        BIT_HI,
        ACK_LO,
        ACK_HI,
        NEXT,
        STOP_LO,
        STOP_HI,
        STOP_END
    } state_t;

    state_t        state;
    logic [PW-1:0] phase_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    cur_byte;
    logic          cur_last;
    logic [1:0]    sda_sync;

    // Only IDLE and NEXT take a byte; every other state leaves the source holding it.
    assign in_ready = (state == IDLE) || (state == NEXT);

    // The pads are open drain: only the enables ever change.
    assign scl_out = 1'b0;
    assign sda_out = 1'b0;

    // Two-flop synchroniser; reset to 1 so a released bus reads as idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sda_sync <= 2'b11;
        end else begin
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

    // Each transition loads the pad enables for the state being entered, so
    // the outputs come straight from flops. Phase states count phase_cnt down
    // from RELOAD and leave when it reaches zero; IDLE and NEXT wait for a byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            bit_idx    <= '0;
            cur_byte   <= '0;
            cur_last   <= 1'b0;
            scl_en     <= 1'b0;
            sda_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            bytes_sent <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur_byte   <= in_data;
                        cur_last   <= in_last;
                        ack_err    <= 1'b0;
                        bytes_sent <= '0;
                        busy       <= 1'b1;
                        scl_en     <= 1'b0;
                        sda_en     <= 1'b1;
                        phase_cnt  <= RELOAD;
                        state      <= START;
                    end
                end
                NEXT: begin
                    if (in_valid) begin
                        cur_byte  <= in_data;
                        cur_last  <= in_last;
                        bit_idx   <= '0;
                        scl_en    <= 1'b1;
                        sda_en    <= ~in_data[0];
                        phase_cnt <= RELOAD;
                        state     <= BIT_LO;
                    end
                end
                default: begin
                    if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - PW'(1);
                    end else begin
                        phase_cnt <= RELOAD;
                        case (state)
                            START: begin
                                bit_idx <= '0;
                                scl_en  <= 1'b1;
                                sda_en  <= ~cur_byte[0];
                                state   <= BIT_LO;
                            end
                            BIT_LO: begin
                                scl_en <= 1'b0;
                                state  <= BIT_HI;
                            end
                            BIT_HI: begin
                                scl_en <= 1'b1;
                                if (bit_idx != 3'd7) begin
                                    bit_idx <= bit_idx + 3'd1;
                                    sda_en  <= ~cur_byte[bit_idx + 3'd1];
                                    state   <= BIT_LO;
                                end else begin
                                    sda_en <= 1'b0;
                                    state  <= ACK_LO;
                                end
                            end
                            ACK_LO: begin
                                scl_en <= 1'b0;
                                state  <= ACK_HI;
                            end
                            ACK_HI: begin
                                // Last cycle of the high half: a released SDA means NACK.
                                if (sda_sync[1]) begin
                                    ack_err <= 1'b1;
                                end
                                if (bytes_sent != {CNT_W{1'b1}}) begin
                                    bytes_sent <= bytes_sent + CNT_W'(1);
                                end
                                scl_en <= 1'b1;
                                if (cur_last || (sda_sync[1] && ABORT_ON_NACK)) begin
                                    sda_en <= 1'b1;
                                    state  <= STOP_LO;
                                end else begin
                                    sda_en <= 1'b0;
                                    state  <= NEXT;
                                end
                            end
                            STOP_LO: begin
                                scl_en <= 1'b0;
                                sda_en <= 1'b1;
                                state  <= STOP_HI;
                            end
                            STOP_HI: begin
                                scl_en <= 1'b0;
                                sda_en <= 1'b0;
                                state  <= STOP_END;
                            end
                            STOP_END: begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tm1637_frame_xfer.sv
// ---------------------------------------------------------------------------
// tb_tm1637_frame_xfer
//
// Two instances share one stimulus stream: dut_a aborts on NACK (CNT_W=8),
// dut_c continues on NACK with a 2-bit saturating byte count. 'sel' chooses
// which one receives in_valid and which one drives the observed bus. A bus
// monitor decodes start/stop conditions and bytes from the pad enables and
// plays an I2C-style slave that ACKs or NACKs each byte from a plan queue.
// Expected results come from the frame rules: which bytes go out, the NACK
// flag, the byte count and the start-to-done time.
// ---------------------------------------------------------------------------
module tb_tm1637_frame_xfer;

    localparam int HP       = 4;
    localparam int WAIT_MAX = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       slave_pull = 1'b0;
    logic       sda_line;

    logic       a_ready, a_busy, a_done, a_ack_err, a_scl_en, a_scl_out, a_sda_en, a_sda_out;
    logic [7:0] a_bytes_sent;
    logic       c_ready, c_busy, c_done, c_ack_err, c_scl_en, c_scl_out, c_sda_en, c_sda_out;
    logic [1:0] c_bytes_sent;

    logic       m_ready, m_busy, m_done, m_ack_err, m_scl_en, m_scl_out, m_sda_en, m_sda_out;
    logic [7:0] m_bytes_sent;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] tx [16];
    bit         plan [16];
    logic [7:0] obs_q [$];
    bit         nack_q [$];
    int         starts = 0;
    int         stops = 0;
    int         nx_cnt = 0;
    int         nx_ok = 0;

    bit         prev_scl = 1'b1;
    bit         prev_sda = 1'b1;
    bit         scl_now, sda_now;
    int         bit_cnt = 0;
    logic [7:0] shreg = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign m_ready      = sel ? c_ready   : a_ready;
    assign m_busy       = sel ? c_busy    : a_busy;
    assign m_done       = sel ? c_done    : a_done;
    assign m_ack_err    = sel ? c_ack_err : a_ack_err;
    assign m_scl_en     = sel ? c_scl_en  : a_scl_en;
    assign m_scl_out    = sel ? c_scl_out : a_scl_out;
    assign m_sda_en     = sel ? c_sda_en  : a_sda_en;
    assign m_sda_out    = sel ? c_sda_out : a_sda_out;
    assign m_bytes_sent = sel ? {6'b0, c_bytes_sent} : a_bytes_sent;
    assign sda_line     = ~(m_sda_en | slave_pull);

    tm1637_frame_xfer #(.HALF_PERIOD(HP), .ABORT_ON_NACK(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(a_ready),
        .in_data(in_data), .in_last(in_last), .busy(a_busy), .done(a_done),
        .ack_err(a_ack_err), .bytes_sent(a_bytes_sent), .scl_en(a_scl_en),
        .scl_out(a_scl_out), .sda_en(a_sda_en), .sda_out(a_sda_out), .sda_in(sda_line)
    );

    tm1637_frame_xfer #(.HALF_PERIOD(HP), .ABORT_ON_NACK(1'b0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(c_ready),
        .in_data(in_data), .in_last(in_last), .busy(c_busy), .done(c_done),
        .ack_err(c_ack_err), .bytes_sent(c_bytes_sent), .scl_en(c_scl_en),
        .scl_out(c_scl_out), .sda_en(c_sda_en), .sda_out(c_sda_out), .sda_in(sda_line)
    );

    // Bus monitor and slave: decodes the selected DUT's pads every falling clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
            bit_cnt    = 0;
            slave_pull = 1'b0;
        end else begin
            scl_now = !m_scl_en;
            sda_now = !(m_sda_en || slave_pull);
            if (prev_scl && scl_now && prev_sda && !sda_now) begin
                starts++;
                bit_cnt = 0;
            end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
                stops++;
                bit_cnt = 0;
            end
            if (!prev_scl && scl_now) begin
                if (bit_cnt < 8) begin
                    shreg[bit_cnt] = sda_now;
                    bit_cnt++;
                    if (bit_cnt == 8) obs_q.push_back(shreg);
                end else if (bit_cnt == 8) begin
                    bit_cnt = 9;
                end
            end
            if (prev_scl && !scl_now) begin
                if (bit_cnt == 8) begin
                    if (nack_q.size() > 0) slave_pull = !nack_q.pop_front();
                    else                   slave_pull = 1'b1;
                end else if (bit_cnt == 9) begin
                    slave_pull = 1'b0;
                    bit_cnt    = 0;
                end
            end
            if (m_busy && m_ready) begin
                nx_cnt++;
                if (m_scl_en && !m_sda_en) nx_ok++;
            end
            prev_scl = scl_now;
            prev_sda = !(m_sda_en || slave_pull);
        end
    end

    // Reference: number of bytes that go out of an n-byte frame.
    function automatic int model_count(input int n, input bit abort);
        for (int i = 0; i < n; i++) begin
            if (abort && plan[i]) return i + 1;
        end
        return n;
    endfunction

    function automatic bit model_err(input int k);
        for (int i = 0; i < k; i++) begin
            if (plan[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Start, 18 phases per byte, 3 stop phases; each immediate hand-off adds one NEXT cycle.
    function automatic int model_latency(input int k);
        return (4 + 18 * k) * HP + (k - 1);
    endfunction

    // Offers tx[0..n-1]; waits 'gap' cycles in NEXT before each later byte.
    // Stops offering when the frame ends early. Returns bytes accepted and
    // the cycles from the first accept to done.
    task automatic run_frame(input int n, input int gap, output int k_acc, output int lat);
        int  acc0;
        int  dcyc;
        bit  fin;
        obs_q.delete();
        nack_q.delete();
        starts = 0;
        stops  = 0;
        nx_cnt = 0;
        nx_ok  = 0;
        for (int i = 0; i < n; i++) nack_q.push_back(plan[i]);
        k_acc = 0;
        acc0  = 0;
        dcyc  = -1;
        fin   = 1'b0;
        for (int i = 0; i < n && !fin; i++) begin
            @(negedge clk);
            for (int w = 0; w < WAIT_MAX && !m_ready && !m_done; w++) @(negedge clk);
            if (m_done) begin
                dcyc = cyc;
                fin  = 1'b1;
            end else if (!m_ready) begin
                checks++;
                errors++;
                $display("[TB] FAIL handshake_timeout byte %0d: in_ready=%0b, required 1", i, m_ready);
                fin = 1'b1;
            end else begin
                if (i > 0) repeat (gap) @(negedge clk);
                in_data  = tx[i];
                in_last  = (i == n - 1);
                in_valid = 1'b1;
                if (i == 0) acc0 = cyc + 1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                k_acc++;
            end
        end
        if (dcyc < 0) begin
            for (int w = 0; w < WAIT_MAX; w++) begin
                @(negedge clk);
                if (m_done) begin
                    dcyc = cyc;
                    break;
                end
            end
            if (dcyc < 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL done_timeout: done never pulsed within %0d cycles", WAIT_MAX);
            end
        end
        lat = (dcyc < 0) ? -1 : dcyc - acc0;
    endtask

    task automatic test_reset();
        int k_acc, lat;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_scl_en, a_sda_en, a_busy, a_done, a_ack_err} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: scl_en/sda_en/busy/done/ack_err=%b, required 00000",
                     {a_scl_en, a_sda_en, a_busy, a_done, a_ack_err});
        end
        checks++;
        if (a_bytes_sent !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_bytes_sent: got %0d, required 0", a_bytes_sent);
        end
        checks++;
        if ({a_ready, a_scl_out, a_sda_out} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL reset_ready_pads: in_ready/scl_out/sda_out=%b, required 100",
                     {a_ready, a_scl_out, a_sda_out});
        end
        rst = 1'b1;

        // Start a frame whose bit 0 is zero so SDA is pulled in BIT_LO, then reset mid-bit.
        @(negedge clk);
        in_data  = 8'($urandom) & 8'hFE;
        in_last  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int w = 0; w < WAIT_MAX && !a_scl_en; w++) @(negedge clk);
        checks++;
        if (a_scl_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_reach_bit_lo: scl_en=%b, required 1", a_scl_en);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({a_scl_en, a_sda_en, a_busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_mid_frame: scl_en/sda_en/busy=%b, required 000",
                     {a_scl_en, a_sda_en, a_busy});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_ready, a_busy, stops} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("[TB] FAIL reset_release: in_ready=%b busy=%b stops=%0d, required 1 0 0",
                     a_ready, a_busy, stops);
        end

        tx[0]   = 8'($urandom);
        plan[0] = 1'b0;
        run_frame(1, 0, k_acc, lat);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== tx[0]) begin
            errors++;
            $display("[TB] FAIL reset_next_frame_byte: got %0d bytes first=%h, required 1 byte %h",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx, tx[0]);
        end
        checks++;
        if (lat != model_latency(1)) begin
            errors++;
            $display("[TB] FAIL reset_next_frame_latency: got %0d, required %0d", lat, model_latency(1));
        end
    endtask

    task automatic test_single_byte();
        int k_acc, lat;
        sel     = 1'b0;
        tx[0]   = 8'h40;
        plan[0] = 1'b0;
        run_frame(1, 0, k_acc, lat);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 8'h40) begin
            errors++;
            $display("[TB] FAIL single_byte_bits: got %0d bytes first=%h, required 1 byte 40",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
        end
        checks++;
        if (lat != 88) begin
            errors++;
            $display("[TB] FAIL single_byte_latency: got %0d, required 88", lat);
        end
        checks++;
        if ({m_ack_err, m_bytes_sent} !== {1'b0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL single_byte_status: ack_err=%b bytes_sent=%0d, required 0 1",
                     m_ack_err, m_bytes_sent);
        end
        checks++;
        if ({m_scl_en, m_sda_en, starts, stops} !== {2'b00, 32'd1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL single_byte_bus: scl_en=%b sda_en=%b starts=%0d stops=%0d, required 0 0 1 1",
                     m_scl_en, m_sda_en, starts, stops);
        end
    endtask

    task automatic test_gap();
        int k_acc, lat;
        sel     = 1'b0;
        tx[0]   = 8'hC0;
        tx[1]   = 8'h3F;
        plan[0] = 1'b0;
        plan[1] = 1'b0;
        run_frame(2, 50, k_acc, lat);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 8'hC0 || obs_q[1] !== 8'h3F) begin
            errors++;
            $display("[TB] FAIL gap_bytes: got %0d bytes, required C0 3F", obs_q.size());
        end
        checks++;
        if (nx_cnt != 51 || nx_ok != nx_cnt) begin
            errors++;
            $display("[TB] FAIL gap_idle_lines: gap cycles=%0d with SCL low/SDA free=%0d, required 51 51",
                     nx_cnt, nx_ok);
        end
        checks++;
        if (lat != 40 * HP + 51) begin
            errors++;
            $display("[TB] FAIL gap_latency: got %0d, required %0d", lat, 40 * HP + 51);
        end
        checks++;
        if ({m_ack_err, m_bytes_sent} !== {1'b0, 8'd2}) begin
            errors++;
            $display("[TB] FAIL gap_status: ack_err=%b bytes_sent=%0d, required 0 2", m_ack_err, m_bytes_sent);
        end
    endtask

    task automatic test_abort_nack();
        int k_acc, lat, k;
        sel = 1'b0;
        for (int i = 0; i < 3; i++) tx[i] = 8'($urandom);
        plan[0] = 1'b1;
        plan[1] = 1'b0;
        plan[2] = 1'b0;
        k = model_count(3, 1'b1);
        run_frame(3, 0, k_acc, lat);
        checks++;
        if (k_acc != k || obs_q.size() != k) begin
            errors++;
            $display("[TB] FAIL abort_byte_count: accepted=%0d on bus=%0d, required %0d", k_acc, obs_q.size(), k);
        end
        checks++;
        if ({m_ack_err, m_bytes_sent} !== {1'b1, 8'd1}) begin
            errors++;
            $display("[TB] FAIL abort_status: ack_err=%b bytes_sent=%0d, required 1 1", m_ack_err, m_bytes_sent);
        end
        checks++;
        if (nx_cnt != 0 || stops != 1) begin
            errors++;
            $display("[TB] FAIL abort_ready_stop: ready-while-busy cycles=%0d stops=%0d, required 0 1",
                     nx_cnt, stops);
        end
        checks++;
        if (lat != model_latency(1)) begin
            errors++;
            $display("[TB] FAIL abort_latency: got %0d, required %0d", lat, model_latency(1));
        end
    endtask

    task automatic test_continue_nack();
        int k_acc, lat;
        sel = 1'b1;
        for (int i = 0; i < 3; i++) tx[i] = 8'($urandom);
        plan[0] = 1'b0;
        plan[1] = 1'b1;
        plan[2] = 1'b0;
        run_frame(3, 0, k_acc, lat);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_q.size() <= i || obs_q[i] !== tx[i]) begin
                errors++;
                $display("[TB] FAIL continue_byte%0d: got %h, required %h", i,
                         (obs_q.size() > i) ? obs_q[i] : 8'hxx, tx[i]);
            end
        end
        checks++;
        if ({m_ack_err, m_bytes_sent} !== {1'b1, 8'd3}) begin
            errors++;
            $display("[TB] FAIL continue_status: ack_err=%b bytes_sent=%0d, required 1 3", m_ack_err, m_bytes_sent);
        end
        checks++;
        if (lat != model_latency(3)) begin
            errors++;
            $display("[TB] FAIL continue_latency: got %0d, required %0d", lat, model_latency(3));
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acc1, d1, d2;
        sel = 1'b0;
        obs_q.delete();
        nack_q.delete();
        starts = 0;
        stops  = 0;
        tx[0]  = 8'($urandom);
        tx[1]  = 8'($urandom);
        nack_q.push_back(1'b1);
        nack_q.push_back(1'b0);
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        in_data  = tx[0];
        in_last  = 1'b1;
        in_valid = 1'b1;
        acc1     = cyc + 1;
        @(posedge clk);
        #1;
        in_data = tx[1];
        for (int w = 0; w < WAIT_MAX; w++) begin
            @(negedge clk);
            if (m_done) begin
                d1 = cyc;
                break;
            end
        end
        checks++;
        if (d1 - acc1 != 88 || {m_ack_err, m_bytes_sent} !== {1'b1, 8'd1}) begin
            errors++;
            $display("[TB] FAIL b2b_first_frame: latency=%0d ack_err=%b bytes_sent=%0d, required 88 1 1",
                     d1 - acc1, m_ack_err, m_bytes_sent);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_busy, m_ready, m_scl_en, m_sda_en} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL b2b_start_next_cycle: busy/ready/scl_en/sda_en=%b, required 1001",
                     {m_busy, m_ready, m_scl_en, m_sda_en});
        end
        checks++;
        if ({m_ack_err, m_bytes_sent} !== {1'b0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL b2b_status_clear: ack_err=%b bytes_sent=%0d, required 0 0", m_ack_err, m_bytes_sent);
        end
        for (int w = 0; w < WAIT_MAX; w++) begin
            @(negedge clk);
            if (m_done) begin
                d2 = cyc;
                break;
            end
        end
        checks++;
        if (d2 - (d1 + 1) != 88 || {m_ack_err, m_bytes_sent} !== {1'b0, 8'd1}) begin
            errors++;
            $display("[TB] FAIL b2b_second_frame: latency=%0d ack_err=%b bytes_sent=%0d, required 88 0 1",
                     d2 - (d1 + 1), m_ack_err, m_bytes_sent);
        end
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== tx[0] || obs_q[1] !== tx[1] || starts != 2 || stops != 2) begin
            errors++;
            $display("[TB] FAIL b2b_bus: bytes=%0d starts=%0d stops=%0d, required 2 2 2 with %h %h",
                     obs_q.size(), starts, stops, tx[0], tx[1]);
        end
    endtask

    task automatic test_random();
        int n, gap, k, k_acc, lat, exp_bs;
        bit err;
        for (int f = 0; f < 10; f++) begin
            @(negedge clk);
            sel = 1'($urandom_range(0, 1));
            n   = $urandom_range(1, 4);
            gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                tx[i]   = 8'($urandom);
                plan[i] = ($urandom_range(0, 3) == 0);
            end
            k      = model_count(n, !sel);
            err    = model_err(k);
            exp_bs = (sel && k > 3) ? 3 : k;
            run_frame(n, gap, k_acc, lat);
            checks++;
            if (k_acc != k || obs_q.size() != k) begin
                errors++;
                $display("[TB] FAIL rand%0d_count: accepted=%0d on bus=%0d, required %0d", f, k_acc, obs_q.size(), k);
            end
            for (int i = 0; i < k; i++) begin
                checks++;
                if (obs_q.size() <= i || obs_q[i] !== tx[i]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_byte%0d: got %h, required %h", f, i,
                             (obs_q.size() > i) ? obs_q[i] : 8'hxx, tx[i]);
                end
            end
            checks++;
            if (m_ack_err !== err || m_bytes_sent !== 8'(exp_bs)) begin
                errors++;
                $display("[TB] FAIL rand%0d_status: ack_err=%b bytes_sent=%0d, required %b %0d",
                         f, m_ack_err, m_bytes_sent, err, exp_bs);
            end
            if (gap == 0) begin
                checks++;
                if (lat != model_latency(k)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_latency: got %0d, required %0d", f, lat, model_latency(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_gap();
        test_abort_nack();
        test_continue_nack();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
